sram_bus_master: RTL and testbench
==================================

SRAM_BUS_MASTER -- requirements
Module: sram_bus_master

Interface
REQ-001 The block SHALL have parameter ADDRLEN, default 8, meaning the external memory address width in bits.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 6, meaning the clock cycles a strobe (mem_oe_ or mem_we_) stays low; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, ADDRLEN bits: the request address.
REQ-009 The block SHALL have port req_wdata, input, 8 bits: the write data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle read-data-valid pulse.
REQ-011 The block SHALL have port rsp_rdata, output, 8 bits: the captured read data.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-013 The block SHALL have port mem_oe_, output, 1 bit: the active-low memory output enable.
REQ-014 The block SHALL have port mem_we_, output, 1 bit: the active-low memory write enable.
REQ-015 The block SHALL have port mem_addr, output, ADDRLEN bits: the memory address.
REQ-016 The block SHALL have port mem_data, inout, 8 bits: the bidirectional memory data bus.

Function
REQ-017 A handshake SHALL occur on a rising edge where req_valid and req_ready are both 1; at that edge the block latches req_write, req_addr and req_wdata.
REQ-018 The FSM SHALL have exactly these states: IDLE, SETUP, READ_WAIT, WRITE_WAIT, RECOVER.
REQ-019 req_ready SHALL be 1 only when the state is IDLE and reset is 0; req_valid in any other state SHALL be ignored.
REQ-020 IDLE SHALL go to SETUP on a handshake and otherwise stay in IDLE.
REQ-021 SETUP SHALL last exactly 1 cycle, with mem_addr driven and both strobes high; it SHALL then go to WRITE_WAIT if the latched req_write is 1, and to READ_WAIT otherwise.
REQ-022 READ_WAIT and WRITE_WAIT SHALL each last exactly WAIT_CYCLES cycles, using a down-counter loaded on SETUP exit; they SHALL then go to RECOVER.
REQ-023 RECOVER SHALL last exactly 1 cycle, with both strobes high, and SHALL then go to IDLE.
REQ-024 mem_oe_ SHALL be 0 only in READ_WAIT, and mem_we_ SHALL be 0 only in WRITE_WAIT; both SHALL be driven from registers (glitch-free) and SHALL never be 0 in the same cycle.
REQ-025 mem_addr SHALL hold the latched address, unchanged, from SETUP through RECOVER, and SHALL hold its last value while IDLE.
REQ-026 mem_data SHALL be driven with the latched wdata only in SETUP, WRITE_WAIT and RECOVER of a write, and SHALL be high-impedance at all other times, including every read.
REQ-027 On the edge that leaves READ_WAIT, the block SHALL capture mem_data into rsp_rdata.
REQ-028 rsp_valid SHALL be 1 for exactly the RECOVER cycle of a read, and SHALL be 0 for writes.
REQ-029 rsp_rdata SHALL hold its value until the next read capture.
REQ-030 Read latency SHALL be as follows: for a handshake on edge E, rsp_valid SHALL go high after edge E+WAIT_CYCLES+1.
REQ-031 The next handshake SHALL be possible no earlier than edge E+WAIT_CYCLES+3, giving one transaction per WAIT_CYCLES+3 cycles.
REQ-032 WAIT_CYCLES=1 SHALL produce a single-cycle strobe with no counter underflow.
REQ-033 Address all-ones SHALL need no special handling; there is no auto-increment and no wrap.

Reset
REQ-034 On any edge with reset=1, the block SHALL go to IDLE, set mem_oe_=1 and mem_we_=1, release mem_data to high-impedance, and set rsp_valid=0, rsp_rdata=8'h00, mem_addr=0 and the counter to 0.
REQ-035 A reset that arrives mid-transaction SHALL abort the transaction: the strobe deasserts on that edge, no rsp_valid is produced, and the memory content is undefined if a write was aborted.
REQ-036 The first handshake after reset SHALL be possible on the first edge where reset=0.

Verification
REQ-037 Reset check: hold reset for 2 cycles mid-idle -> mem_oe_=1, mem_we_=1, mem_data=Z, rsp_valid=0, rsp_rdata=8'h00, busy=0; req_ready=1 after release.
REQ-038 Write check: write 8'hA5 to address 8'h10 -> mem_we_ low for exactly 6 cycles; mem_data=8'hA5 for 8 cycles (SETUP through RECOVER); mem_oe_ stays 1; rsp_valid stays 0.
REQ-039 Read check: read address 8'h10 with the bench memory model holding 8'hA5 -> mem_oe_ low for 6 cycles with mem_data at Z from the controller side; rsp_valid high for 1 cycle after edge E+7 with rsp_rdata=8'hA5.
REQ-040 Back-to-back check: hold req_valid high across two reads (8'h00 then 8'h01) -> the second handshake occurs exactly 9 cycles after the first, and the strobes never overlap.
REQ-041 Mid-read reset check: assert reset in the 3rd READ_WAIT cycle -> mem_oe_=1 on that edge, no rsp_valid, rsp_rdata=8'h00, req_ready=1 after release.
REQ-042 Minimum-wait check: build with WAIT_CYCLES=1 and read address 8'hFF holding 8'h3C -> mem_oe_ low for 1 cycle; rsp_valid after edge E+2 with rsp_rdata=8'h3C; next handshake at E+4.

Source files
------------

// File: rtl/sram_bus_master.sv
// Single-port asynchronous SRAM master: one 8-bit read or write per request,
// with fixed-length registered strobes and a turnaround cycle either side.
module sram_bus_master #(
  parameter int ADDRLEN     = 8,
  parameter int WAIT_CYCLES = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDRLEN-1:0] req_addr,
  input  logic [7:0]         req_wdata,
  output logic               rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic               busy,
  output logic               mem_oe_,
  output logic               mem_we_,
  output logic [ADDRLEN-1:0] mem_addr,
  inout  wire  [7:0]         mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ_WAIT,
    WRITE_WAIT,
    RECOVER
  } state_t;

  localparam logic [7:0] LOAD = 8'(WAIT_CYCLES - 1);

  state_t             r_state;
  logic [7:0]         r_cnt;
  logic               r_write;
  logic [7:0]         r_wdata;
  logic               r_drive;
  logic               r_oe_n;
  logic               r_we_n;
  logic               r_rsp_valid;
  logic [7:0]         r_rdata;
  logic [ADDRLEN-1:0] r_addr;
  logic               w_hs;

  assign req_ready = (r_state == IDLE) && !reset;
  assign w_hs      = req_valid && req_ready;
  assign busy      = (r_state != IDLE);
  assign mem_oe_   = r_oe_n;
  assign mem_we_   = r_we_n;
  assign mem_addr  = r_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign mem_data  = r_drive ? r_wdata : 8'hzz;

  // Counter holds remaining strobe cycles minus one, so WAIT_CYCLES=1 exits at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 8'h00;
      r_write     <= 1'b0;
      r_wdata     <= 8'h00;
      r_drive     <= 1'b0;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 8'h00;
      r_addr      <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_drive <= req_write;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_cnt <= LOAD;
          if (r_write) begin
            r_we_n  <= 1'b0;
            r_state <= WRITE_WAIT;
          end else begin
            r_oe_n  <= 1'b0;
            r_state <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (r_cnt == 8'h00) begin
            r_oe_n      <= 1'b1;
            r_rdata     <= mem_data;
            r_rsp_valid <= 1'b1;
            r_state     <= RECOVER;
          end else begin
            r_cnt <= r_cnt - 8'h01;
          end
        end
        WRITE_WAIT: begin
          if (r_cnt == 8'h00) begin
            r_we_n  <= 1'b1;
            r_state <= RECOVER;
          end else begin
            r_cnt <= r_cnt - 8'h01;
          end
        end
        RECOVER: begin
          r_drive <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_master.sv
// Directed bench for sram_bus_master: a WAIT_CYCLES=6 instance and a
// WAIT_CYCLES=1 instance, each on its own pulled-up bus with an SRAM model.
module tb_sram_bus_master;

  logic       clk = 1'b0;
  logic       rst6, rst1, v6, v1;
  logic       rdy6, rdy1, rv6, rv1;
  logic       busy6, busy1;
  logic       oe6, we6, oe1, we1;
  logic       wr;
  logic [7:0] addr, wd;
  logic [7:0] rd6, rd1, ma6, ma1;
  wire  [7:0] md6, md1;

  logic [7:0] mem6 [256];
  logic [7:0] mem1 [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_bus_master #(.ADDRLEN(8), .WAIT_CYCLES(6)) u6 (
    .clk(clk), .reset(rst6),
    .req_valid(v6), .req_ready(rdy6),
    .req_write(wr), .req_addr(addr), .req_wdata(wd),
    .rsp_valid(rv6), .rsp_rdata(rd6), .busy(busy6),
    .mem_oe_(oe6), .mem_we_(we6),
    .mem_addr(ma6), .mem_data(md6)
  );

  sram_bus_master #(.ADDRLEN(8), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(rst1),
    .req_valid(v1), .req_ready(rdy1),
    .req_write(wr), .req_addr(addr), .req_wdata(wd),
    .rsp_valid(rv1), .rsp_rdata(rd1), .busy(busy1),
    .mem_oe_(oe1), .mem_we_(we1),
    .mem_addr(ma1), .mem_data(md1)
  );

  // Released bus floats up to all-ones.
  for (genvar b = 0; b < 8; b++) begin : g_pu
    pullup (md6[b]);
    pullup (md1[b]);
  end

  assign md6 = !oe6 ? mem6[ma6] : 8'hzz;
  assign md1 = !oe1 ? mem1[ma1] : 8'hzz;

  always @(posedge clk) begin
    if (rst6) begin
      mem6[8'h00] <= 8'h11;
      mem6[8'h01] <= 8'h22;
    end else if (!we6) begin
      mem6[ma6] <= md6;
    end
  end

  always @(posedge clk) begin
    if (rst1) mem1[8'hFF] <= 8'h3C;
    else if (!we1) mem1[ma1] <= md1;
  end

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rel(input logic [7:0] d);
    return ((d === 8'hzz) || (d === 8'hFF)) ? 8'h01 : 8'h00;
  endfunction

  int n_we, n_oe, n_d, n_rv, n_ov, n_hs;
  int hs [2];

  initial begin
    rst6 = 1'b1; rst1 = 1'b1;
    v6 = 1'b0; v1 = 1'b0;
    wr = 1'b0; addr = 8'h00; wd = 8'h00;

    // Reset held for two edges while idle
    repeat (2) @(negedge clk);
    chk("rst_oe", {7'd0, oe6}, 8'h01);
    chk("rst_we", {7'd0, we6}, 8'h01);
    chk("rst_bus", rel(md6), 8'h01);
    chk("rst_rv", {7'd0, rv6}, 8'h00);
    chk("rst_rd", rd6, 8'h00);
    chk("rst_busy", {7'd0, busy6}, 8'h00);
    chk("rst_rdy", {7'd0, rdy6}, 8'h00);
    chk("rst_addr", ma6, 8'h00);
    rst6 = 1'b0; rst1 = 1'b0;
    #1 chk("rel_rdy", {7'd0, rdy6}, 8'h01);

    // Write A5 to 0x10
    @(negedge clk);
    v6 = 1'b1; wr = 1'b1; addr = 8'h10; wd = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    v6 = 1'b0;
    n_we = 0; n_oe = 0; n_d = 0; n_rv = 0;
    for (int j = 0; j < 10; j++) begin
      if (!we6) n_we++;
      if (!oe6) n_oe++;
      if (md6 === 8'hA5) n_d++;
      if (rv6) n_rv++;
      if (j == 0) chk("wr_addr", ma6, 8'h10);
      if (j == 0) chk("wr_busy", {7'd0, busy6}, 8'h01);
      if (j == 7) chk("wr_rdy7", {7'd0, rdy6}, 8'h00);
      if (j == 8) chk("wr_rdy8", {7'd0, rdy6}, 8'h01);
      @(negedge clk);
    end
    chk("wr_we_len", 8'(n_we), 8'd6);
    chk("wr_d_len", 8'(n_d), 8'd8);
    chk("wr_oe_len", 8'(n_oe), 8'd0);
    chk("wr_rv", 8'(n_rv), 8'd0);
    chk("wr_mem", mem6[8'h10], 8'hA5);

    // Read back 0x10
    v6 = 1'b1; wr = 1'b0; addr = 8'h10; wd = 8'h00;
    @(posedge clk);
    @(negedge clk);
    v6 = 1'b0;
    n_we = 0; n_oe = 0; n_rv = 0;
    for (int j = 0; j < 10; j++) begin
      if (!we6) n_we++;
      if (!oe6) n_oe++;
      if (rv6) n_rv++;
      if (j == 0) chk("rd_setup_bus", rel(md6), 8'h01);
      if (j == 3) chk("rd_mid_bus", md6, 8'hA5);
      if (j == 6) chk("rd_rv6", {7'd0, rv6}, 8'h00);
      if (j == 7) chk("rd_rv7", {7'd0, rv6}, 8'h01);
      if (j == 7) chk("rd_data", rd6, 8'hA5);
      @(negedge clk);
    end
    chk("rd_oe_len", 8'(n_oe), 8'd6);
    chk("rd_we_len", 8'(n_we), 8'd0);
    chk("rd_rv_cnt", 8'(n_rv), 8'd1);
    chk("rd_hold", rd6, 8'hA5);

    // Back-to-back reads of 0x00 then 0x01
    v6 = 1'b1; wr = 1'b0; addr = 8'h00;
    n_hs = 0; n_ov = 0;
    for (int c = 0; c < 25; c++) begin
      if (n_hs == 1) addr = 8'h01;
      if (n_hs == 2) v6 = 1'b0;
      if (!oe6 && !we6) n_ov++;
      if (v6 && rdy6 && n_hs < 2) begin
        hs[n_hs] = c;
        n_hs++;
      end
      @(negedge clk);
    end
    v6 = 1'b0;
    chk("b2b_count", 8'(n_hs), 8'd2);
    if (n_hs == 2) chk("b2b_gap", 8'(hs[1] - hs[0]), 8'd9);
    chk("b2b_overlap", 8'(n_ov), 8'd0);
    chk("b2b_data", rd6, 8'h22);

    // Reset during the third READ_WAIT cycle
    v6 = 1'b1; wr = 1'b0; addr = 8'h10;
    @(posedge clk);
    @(negedge clk);
    v6 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_oe_pre", {7'd0, oe6}, 8'h00);
    rst6 = 1'b1;
    @(negedge clk);
    chk("mr_oe", {7'd0, oe6}, 8'h01);
    chk("mr_rv", {7'd0, rv6}, 8'h00);
    chk("mr_rd", rd6, 8'h00);
    chk("mr_busy", {7'd0, busy6}, 8'h00);
    rst6 = 1'b0;
    #1 chk("mr_rdy", {7'd0, rdy6}, 8'h01);
    n_rv = 0;
    repeat (10) begin
      @(negedge clk);
      if (rv6) n_rv++;
    end
    chk("mr_no_rv", 8'(n_rv), 8'd0);

    // WAIT_CYCLES=1 read of 0xFF with valid held high
    v1 = 1'b1; wr = 1'b0; addr = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    n_oe = 0;
    for (int j = 0; j < 5; j++) begin
      if (!oe1 && j < 4) n_oe++;
      if (j == 0) chk("w1_addr", ma1, 8'hFF);
      if (j == 1) chk("w1_rv1", {7'd0, rv1}, 8'h00);
      if (j == 2) chk("w1_rv2", {7'd0, rv1}, 8'h01);
      if (j == 2) chk("w1_data", rd1, 8'h3C);
      if (j == 2) chk("w1_rdy2", {7'd0, rdy1}, 8'h00);
      if (j == 3) chk("w1_rdy3", {7'd0, rdy1}, 8'h01);
      if (j == 4) chk("w1_hs4", {7'd0, busy1}, 8'h01);
      if (j == 4) v1 = 1'b0;
      @(negedge clk);
    end
    chk("w1_oe_len", 8'(n_oe), 8'd1);
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
